mem_nch: RTL and testbench

Multi-channel successor to the single-port `memory` block: one WIDTH x DEPTH storage array shared by NUM_CH independent requesters, each with its own valid/ready handshake. A registered round-robin arbiter serves at most one request per clock and returns per-channel read data and an error flag. The block sits wherever several masters (DMA, CPU, debug) need the same scratch RAM.

---
 rtl/mem_nch_pkg.sv | 16 +
 rtl/mem_nch_rr_arbiter.sv | 30 +++
 rtl/mem_nch.sv | 107 ++++++++++
 tb/tb_mem_nch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_nch_pkg.sv
// Shared constants and helpers for the multi-channel scratch memory (mem_nch).
package mem_nch_pkg;

  localparam int MAX_CH    = 8;
  localparam int PAR_MAX_W = 64;

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Even parity over a zero-extended data word; zero padding does not change the result.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_nch_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping, wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_nch.sv
// Multi-channel WIDTH x DEPTH scratch RAM with registered round-robin service, one op per clock.
// Optional feature: define MEM_NCH_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module mem_nch
  import mem_nch_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [NUM_CH-1:0]            valid,
  input  logic [NUM_CH-1:0]            wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*WIDTH-1:0]      wdata,
  output logic [NUM_CH*WIDTH-1:0]      rdata,
  output logic [NUM_CH-1:0]            ready,
  output logic [NUM_CH-1:0]            err
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
`ifdef MEM_NCH_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("mem_nch: NUM_CH out of range");
  end

  logic [MW-1:0]         mem [DEPTH];
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gnt_idx;
  logic [NUM_CH-1:0]     gnt;
  logic                  any;
  logic [ADDR_WIDTH-1:0] addr_ch  [NUM_CH];
  logic [WIDTH-1:0]      wdata_ch [NUM_CH];
  logic [WIDTH-1:0]      rdata_q  [NUM_CH];

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic                  in_range;
  logic [MW-1:0]         rd_word;
  logic [MW-1:0]         wr_word;
  logic                  par_bad;
  logic                  grant_err;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      addr_ch[c]  = addr[slice_lo(c, ADDR_WIDTH) +: ADDR_WIDTH];
      wdata_ch[c] = wdata[slice_lo(c, WIDTH) +: WIDTH];
      rdata[slice_lo(c, WIDTH) +: WIDTH] = rdata_q[c];
    end
  end

  // A channel still showing ready this cycle was just served; masking it prevents double service.
  rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
    .req     (valid & ~ready),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    sel_wr    = wr_rd[gnt_idx];
    sel_addr  = addr_ch[gnt_idx];
    sel_wdata = wdata_ch[gnt_idx];
    in_range  = 32'(sel_addr) < DEPTH_U;
    rd_word   = in_range ? mem[sel_addr] : '0;
`ifdef MEM_NCH_PARITY_EN
    wr_word   = {even_parity(PAR_MAX_W'(sel_wdata)), sel_wdata};
    par_bad   = in_range && (rd_word[WIDTH] != even_parity(PAR_MAX_W'(rd_word[WIDTH-1:0])));
`else
    wr_word   = sel_wdata;
    par_bad   = 1'b0;
`endif
    grant_err = !in_range || (!sel_wr && par_bad);
  end

  // Storage is deliberately not reset; res only blocks a write from landing.
  always_ff @(posedge clk) begin
    if (!res && any && sel_wr && in_range) mem[sel_addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ready  <= '0;
      err    <= '0;
      rr_ptr <= '0;
      for (int c = 0; c < NUM_CH; c++) rdata_q[c] <= '0;
    end else begin
      ready <= gnt;
      err   <= '0;
      if (any) begin
        err[gnt_idx] <= grant_err;
        if (!sel_wr) rdata_q[gnt_idx] <= rd_word[WIDTH-1:0];
        rr_ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_nch.sv
// Scoreboard bench for mem_nch: a 2-channel 32-word instance and a 4-channel 24-word instance.
module tb_mem_nch;

  logic clk = 1'b0;
  logic res = 1'b0;

  logic [1:0]  v2 = '0, w2 = '0;
  logic [9:0]  a2 = '0;
  logic [15:0] d2 = '0;
  logic [15:0] rd2;
  logic [1:0]  rdy2, er2;

  logic [3:0]  v4 = '0, w4 = '0;
  logic [19:0] a4 = '0;
  logic [31:0] d4 = '0;
  logic [31:0] rd4;
  logic [3:0]  rdy4, er4;

  mem_nch dut (
    .clk(clk), .res(res), .valid(v2), .wr_rd(w2), .addr(a2), .wdata(d2),
    .rdata(rd2), .ready(rdy2), .err(er2)
  );

  mem_nch #(.WIDTH(8), .DEPTH(24), .NUM_CH(4)) dut4 (
    .clk(clk), .res(res), .valid(v4), .wr_rd(w4), .addr(a4), .wdata(d4),
    .rdata(rd4), .ready(rdy4), .err(er4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic       wr;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t       q2[$];
  exp_t       q4[$];
  logic [7:0] m2 [32];
  logic [7:0] m4 [32];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected completion for one request, queued in the order the arbiter must serve it.
  task automatic push(input int dv, input int ch, input logic wr, input int a, input logic [7:0] d);
    exp_t e;
    int   depth;
    logic inr;
    depth = (dv == 0) ? 32 : 24;
    inr   = a < depth;
    e.ch  = ch;
    e.wr  = wr;
    e.e   = !inr;
    e.d   = 8'h00;
    if (wr) begin
      if (inr) begin
        if (dv == 0) m2[a] = d;
        else         m4[a] = d;
      end
    end else if (inr) begin
      e.d = (dv == 0) ? m2[a] : m4[a];
    end
    if (dv == 0) q2.push_back(e);
    else         q4.push_back(e);
  endtask

  task automatic drive(input int dv, input int ch, input logic v, input logic wr, input int a, input logic [7:0] d);
    if (dv == 0) begin
      v2[ch] = v; w2[ch] = wr; a2[ch*5 +: 5] = 5'(a); d2[ch*8 +: 8] = d;
    end else begin
      v4[ch] = v; w4[ch] = wr; a4[ch*5 +: 5] = 5'(a); d4[ch*8 +: 8] = d;
    end
  endtask

  function automatic logic rdy(input int dv, input int ch);
    return (dv == 0) ? rdy2[ch] : rdy4[ch];
  endfunction

  // n back-to-back requests on one channel (addr+i, data+i); lat = negedges until the first ready.
  task automatic run(input int dv, input int ch, input int n, input logic wr,
                     input int a, input logic [7:0] d, output int lat);
    int cnt;
    lat = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      drive(dv, ch, 1'b1, wr, a + i, d + 8'(i));
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!rdy(dv, ch) && cnt < 40);
      if (!rdy(dv, ch)) check("timeout", 32'(rdy(dv, ch)), 32'd1);
      if (i == 0) lat = cnt;
    end
    drive(dv, ch, 1'b0, wr, a, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!res) begin
      if (rdy2 != 0) check("sb2_onehot", 32'($countones(rdy2) <= 1), 32'd1);
      for (int c = 0; c < 2; c++) begin
        if (rdy2[c]) begin
          if (q2.size() == 0) check("sb2_extra", 32'(rdy2), 32'd0);
          else begin
            e = q2.pop_front();
            check("sb2_ch", 32'(c), 32'(e.ch));
            if (!e.wr) check("sb2_rdata", 32'(rd2[c*8 +: 8]), 32'(e.d));
            check("sb2_err", 32'(er2[c]), 32'(e.e));
          end
        end
      end
      if (rdy4 != 0) check("sb4_onehot", 32'($countones(rdy4) <= 1), 32'd1);
      for (int c = 0; c < 4; c++) begin
        if (rdy4[c]) begin
          if (q4.size() == 0) check("sb4_extra", 32'(rdy4), 32'd0);
          else begin
            e = q4.pop_front();
            check("sb4_ch", 32'(c), 32'(e.ch));
            if (!e.wr) check("sb4_rdata", 32'(rd4[c*8 +: 8]), 32'(e.d));
            check("sb4_err", 32'(er4[c]), 32'(e.e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, l2, l3, diffs;
    logic [7:0] snap [24];
    logic [7:0] r;
    exp_t pe;

    #1 res = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready2", 32'(rdy2), 32'd0);
    check("rst_err2",   32'(er2),  32'd0);
    check("rst_rdata2", 32'(rd2),  32'd0);
    check("rst_ready4", 32'(rdy4), 32'd0);
    check("rst_rdata4", rd4,       32'd0);
    res = 1'b0;

    // Contention straight after reset: ch0 write wins, ch1 read sees it one edge later.
    push(0, 0, 1'b1, 3, 8'h11);
    push(0, 1, 1'b0, 3, 8'h00);
    fork
      run(0, 0, 1, 1'b1, 3, 8'h11, l0);
      run(0, 1, 1, 1'b0, 3, 8'h00, l1);
    join
    check("cont_lat0", 32'(l0), 32'd1);
    check("cont_lat1", 32'(l1), 32'd2);

    push(0, 0, 1'b1, 15, 8'hA5);
    run(0, 0, 1, 1'b1, 15, 8'hA5, l0);
    check("lat_wr", 32'(l0), 32'd1);
    push(0, 0, 1'b0, 15, 8'h00);
    run(0, 0, 1, 1'b0, 15, 8'h00, l0);
    check("lat_rd", 32'(l0), 32'd1);

    // All four channels streaming: grants must rotate 0,1,2,3,...
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 4; c++) push(1, c, 1'b1, c*4 + i, 8'(c*16 + i));
    fork
      run(1, 0, 8, 1'b1, 0,  8'h00, l0);
      run(1, 1, 8, 1'b1, 4,  8'h10, l1);
      run(1, 2, 8, 1'b1, 8,  8'h20, l2);
      run(1, 3, 8, 1'b1, 12, 8'h30, l3);
    join
    check("fair_lat3", 32'(l3), 32'd4);

    push(1, 2, 1'b0, 3, 8'h00);
    run(1, 2, 1, 1'b0, 3, 8'h00, l0);
    push(1, 2, 1'b0, 30, 8'h00);
    run(1, 2, 1, 1'b0, 30, 8'h00, l0);
    for (int i = 0; i < 24; i++) snap[i] = dut4.mem[i][7:0];
    push(1, 1, 1'b1, 30, 8'h5A);
    run(1, 1, 1, 1'b1, 30, 8'h5A, l0);
    diffs = 0;
    for (int i = 0; i < 24; i++) if (dut4.mem[i][7:0] !== snap[i]) diffs++;
    check("oor_nowrite", 32'(diffs), 32'd0);

    for (int a = 0; a < 32; a++) begin
      r = 8'($urandom);
      push(0, 1, 1'b1, a, r);
      run(0, 1, 1, 1'b1, a, r, l0);
    end
    for (int a = 0; a < 32; a++) begin
      push(0, 0, 1'b0, a, 8'h00);
      run(0, 0, 1, 1'b0, a, 8'h00, l0);
    end
    for (int a = 0; a < 32; a++) check("backdoor", 32'(dut.mem[a][7:0]), 32'(m2[a]));

    // Reset while a ch0 write is pending: outputs clear at once, target word untouched.
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b1, 15, ~m2[15]);
    #2 res = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rdy2), 32'd0);
    check("mid_rst_rdata", 32'(rd2),  32'd0);
    repeat (2) @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, 0, 8'h00);
    res = 1'b0;
    check("mid_rst_keep", 32'(dut.mem[15][7:0]), 32'(m2[15]));

    // Pointer was left at 1 before reset; after reset ch0 must win again.
    push(0, 0, 1'b0, 0, 8'h00);
    push(0, 1, 1'b0, 1, 8'h00);
    fork
      run(0, 0, 1, 1'b0, 0, 8'h00, l0);
      run(0, 1, 1, 1'b0, 1, 8'h00, l1);
    join
    check("rst_ptr_lat1", 32'(l1), 32'd2);

`ifdef MEM_NCH_PARITY_EN
    dut.mem[5][0] = ~dut.mem[5][0];
    pe.ch = 0; pe.wr = 1'b0; pe.d = m2[5] ^ 8'h01; pe.e = 1'b1;
    q2.push_back(pe);
    run(0, 0, 1, 1'b0, 5, 8'h00, l0);
`endif

    repeat (2) @(negedge clk);
    check("sb2_left", 32'(q2.size()), 32'd0);
    check("sb4_left", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
